// File: rtl/btn_mode_ctrl.sv
// Button press classifier: synchronizes a debounced level, classifies presses as short or long,
// and maintains a wrap-around mode register with one-cycle event pulses.
module btn_mode_ctrl #(
  parameter int unsigned NUM_MODES   = 4,
  parameter int unsigned MODE_W      = 2,
  parameter int unsigned LONG_CYCLES = 100000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              db,
  output logic [MODE_W-1:0] mode,
  output logic              short_pulse,
  output logic              long_pulse,
  output logic              pressed
);

  typedef enum logic [1:0] {StIdle, StPress, StHeld} state_e;

  localparam logic [CNT_W-1:0]  HoldLast = CNT_W'(LONG_CYCLES - 1);
  localparam logic [MODE_W-1:0] ModeLast = MODE_W'(NUM_MODES - 1);

  state_e            state_q, state_d;
  logic              s1_q, db_s_q;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              short_q, short_d;
  logic              long_q, long_d;

  // db toggles on a derived enable, so it is treated as asynchronous here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      db_s_q <= 1'b0;
    end else begin
      s1_q   <= db;
      db_s_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      mode_q     <= '0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      mode_q     <= mode_d;
      short_q    <= short_d;
      long_q     <= long_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    mode_d     = mode_q;
    short_d    = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (db_s_q) begin
          state_d    = StPress;
          hold_cnt_d = '0;
        end
      end
      StPress: begin
        // Release wins over reaching the threshold on the same edge.
        if (!db_s_q) begin
          short_d = 1'b1;
          mode_d  = (mode_q == ModeLast) ? '0 : mode_q + 1'b1;
          state_d = StIdle;
        end else if (hold_cnt_q == HoldLast) begin
          long_d  = 1'b1;
          mode_d  = '0;
          state_d = StHeld;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (!db_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mode        = mode_q;
  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign pressed     = (state_q != StIdle);

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Self-checking bench for btn_mode_ctrl (NUM_MODES=3, LONG_CYCLES=8) with a run-length
// reference model of press classification.
module tb_btn_mode_ctrl;

  localparam int NModes  = 3;
  localparam int LongCyc = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       db;
  logic [1:0] mode;
  logic       short_pulse;
  logic       long_pulse;
  logic       pressed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_mode_ctrl #(
    .NUM_MODES  (3),
    .MODE_W     (2),
    .LONG_CYCLES(8),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .db         (db),
    .mode       (mode),
    .short_pulse(short_pulse),
    .long_pulse (long_pulse),
    .pressed    (pressed)
  );

  // Reference model: the level the classifier sees lags db by two edges; a run of
  // LongCyc+1 seen-high edges is a long press, a shorter run ending in a low is short.
  logic hist[$];
  logic seen_m;
  int   run_len  = 0;
  bit   done     = 0;
  int   exp_mode = 0;
  logic exp_short = 1'b0, exp_long = 1'b0, exp_pressed = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist = '{1'b0, 1'b0};
      run_len = 0; done = 0; exp_mode = 0;
      exp_short = 1'b0; exp_long = 1'b0; exp_pressed = 1'b0;
    end else begin
      seen_m = hist.pop_front();
      hist.push_back(db);
      exp_short = 1'b0;
      exp_long  = 1'b0;
      if (seen_m === 1'b1) begin
        run_len++;
        if (run_len == LongCyc + 1) begin
          exp_long = 1'b1; exp_mode = 0; done = 1;
        end
      end else begin
        if (run_len > 0 && !done) begin
          exp_short = 1'b1;
          exp_mode  = (exp_mode + 1) % NModes;
        end
        run_len = 0; done = 0;
      end
      exp_pressed = (run_len > 0);
    end
  end

  task automatic tick(input logic d);
    db = d;
    @(negedge clk);
  endtask

  task automatic test_reset;
    checks++;
    if ({mode, short_pulse, long_pulse, pressed} !== 5'b0) begin
      errors++;
      $display("FAIL por_state got %b want 00000", {mode, short_pulse, long_pulse, pressed});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick((i < 3 || i >= 8) ? 1'b1 : 1'b0);
      checks++;
      if ({mode, short_pulse, long_pulse, pressed} !==
          {2'(exp_mode), exp_short, exp_long, exp_pressed}) begin
        errors++;
        $display("FAIL reset_pre t=%0t got m=%0d s=%b l=%b p=%b want m=%0d s=%b l=%b p=%b",
                 $time, mode, short_pulse, long_pulse, pressed,
                 exp_mode, exp_short, exp_long, exp_pressed);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mode, short_pulse, long_pulse, pressed} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async got %b want 00000", {mode, short_pulse, long_pulse, pressed});
    end
    @(negedge clk);
    checks++;
    if ({mode, short_pulse, long_pulse, pressed} !== 5'b0) begin
      errors++;
      $display("FAIL reset_held got %b want 00000", {mode, short_pulse, long_pulse, pressed});
    end
    db = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick(1'b0);
  endtask

  task automatic test_short_wrap;
    int exp_seq[4] = '{1, 2, 0, 1};
    int nshort = 0, nlong = 0;
    for (int p = 0; p < 4; p++) begin
      int lat = -1;
      logic [1:0] mode_at = 2'b00;
      for (int i = 0; i < 9; i++) begin
        tick(i < 3 ? 1'b1 : 1'b0);
        checks++;
        if ({mode, short_pulse, long_pulse, pressed} !==
            {2'(exp_mode), exp_short, exp_long, exp_pressed}) begin
          errors++;
          $display("FAIL short_model t=%0t got m=%0d s=%b l=%b p=%b want m=%0d s=%b l=%b p=%b",
                   $time, mode, short_pulse, long_pulse, pressed,
                   exp_mode, exp_short, exp_long, exp_pressed);
        end
        if (short_pulse === 1'b1 && lat < 0) begin
          lat = i - 2;
          mode_at = mode;
        end
        nshort += int'(short_pulse);
        nlong  += int'(long_pulse);
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL short_latency press=%0d got %0d want 3", p, lat);
      end
      checks++;
      if (mode_at !== 2'(exp_seq[p])) begin
        errors++;
        $display("FAIL short_mode press=%0d got %0d want %0d", p, mode_at, exp_seq[p]);
      end
    end
    checks++;
    if (nshort != 4 || nlong != 0) begin
      errors++;
      $display("FAIL short_count got s=%0d l=%0d want s=4 l=0", nshort, nlong);
    end
  endtask

  task automatic test_long;
    int long_idx = -1, drop_idx = -1, nlong = 0, nshort = 0;
    for (int i = 0; i < 7; i++) tick(i < 2 ? 1'b1 : 1'b0);
    checks++;
    if (mode !== 2'd2) begin
      errors++;
      $display("FAIL long_setup mode got %0d want 2", mode);
    end
    for (int i = 1; i <= 46; i++) begin
      tick(i <= 40 ? 1'b1 : 1'b0);
      checks++;
      if ({mode, short_pulse, long_pulse, pressed} !==
          {2'(exp_mode), exp_short, exp_long, exp_pressed}) begin
        errors++;
        $display("FAIL long_model t=%0t got m=%0d s=%b l=%b p=%b want m=%0d s=%b l=%b p=%b",
                 $time, mode, short_pulse, long_pulse, pressed,
                 exp_mode, exp_short, exp_long, exp_pressed);
      end
      if (long_pulse === 1'b1 && long_idx < 0) long_idx = i;
      if (i > 40 && pressed === 1'b0 && drop_idx < 0) drop_idx = i - 40;
      nlong  += int'(long_pulse);
      nshort += int'(short_pulse);
    end
    checks++;
    if (long_idx != 11 || nlong != 1) begin
      errors++;
      $display("FAIL long_pulse got idx=%0d n=%0d want idx=11 n=1", long_idx, nlong);
    end
    checks++;
    if (drop_idx != 3 || nshort != 0 || mode !== 2'd0) begin
      errors++;
      $display("FAIL long_release got drop=%0d s=%0d m=%0d want drop=3 s=0 m=0",
               drop_idx, nshort, mode);
    end
  endtask

  task automatic test_threshold;
    for (int len = 8; len <= 9; len++) begin
      int ns = 0, nl = 0;
      for (int i = 0; i < len + 6; i++) begin
        tick(i < len ? 1'b1 : 1'b0);
        checks++;
        if ({mode, short_pulse, long_pulse, pressed} !==
            {2'(exp_mode), exp_short, exp_long, exp_pressed}) begin
          errors++;
          $display("FAIL thr_model t=%0t got m=%0d s=%b l=%b p=%b want m=%0d s=%b l=%b p=%b",
                   $time, mode, short_pulse, long_pulse, pressed,
                   exp_mode, exp_short, exp_long, exp_pressed);
        end
        ns += int'(short_pulse);
        nl += int'(long_pulse);
      end
      checks++;
      if (ns != int'(len == 8) || nl != int'(len == 9)) begin
        errors++;
        $display("FAIL thr_len%0d got s=%0d l=%0d want s=%0d l=%0d",
                 len, ns, nl, int'(len == 8), int'(len == 9));
      end
    end
  endtask

  task automatic test_reset_mid;
    int press_idx = -1, long_idx = -1, ns = 0;
    repeat (3) tick(1'b0);
    repeat (7) tick(1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mode, short_pulse, long_pulse, pressed} !== 5'b0) begin
      errors++;
      $display("FAIL mid_async got %b want 00000", {mode, short_pulse, long_pulse, pressed});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      tick(i <= 14 ? 1'b1 : 1'b0);
      checks++;
      if ({mode, short_pulse, long_pulse, pressed} !==
          {2'(exp_mode), exp_short, exp_long, exp_pressed}) begin
        errors++;
        $display("FAIL mid_model t=%0t got m=%0d s=%b l=%b p=%b want m=%0d s=%b l=%b p=%b",
                 $time, mode, short_pulse, long_pulse, pressed,
                 exp_mode, exp_short, exp_long, exp_pressed);
      end
      if (pressed === 1'b1 && press_idx < 0) press_idx = i;
      if (long_pulse === 1'b1 && long_idx < 0) long_idx = i;
      ns += int'(short_pulse);
    end
    checks++;
    if (press_idx != 3 || long_idx != 11 || ns != 0) begin
      errors++;
      $display("FAIL mid_repress got press=%0d long=%0d s=%0d want press=3 long=11 s=0",
               press_idx, long_idx, ns);
    end
  endtask

  task automatic test_narrow;
    int m0 = exp_mode;
    int ns = 0;
    for (int i = 0; i < 7; i++) begin
      tick(i == 0 ? 1'b1 : 1'b0);
      ns += int'(short_pulse);
    end
    checks++;
    if (ns != 1 || mode !== 2'((m0 + 1) % NModes)) begin
      errors++;
      $display("FAIL narrow got s=%0d m=%0d want s=1 m=%0d", ns, mode, (m0 + 1) % NModes);
    end
  endtask

  task automatic test_random;
    for (int ep = 0; ep < 40; ep++) begin
      int hl = int'($urandom_range(1, 12));
      int ll = int'($urandom_range(1, 6));
      for (int i = 0; i < hl + ll; i++) begin
        tick(i < hl ? 1'b1 : 1'b0);
        checks++;
        if ({mode, short_pulse, long_pulse, pressed} !==
            {2'(exp_mode), exp_short, exp_long, exp_pressed}) begin
          errors++;
          $display("FAIL rand_model t=%0t got m=%0d s=%b l=%b p=%b want m=%0d s=%b l=%b p=%b",
                   $time, mode, short_pulse, long_pulse, pressed,
                   exp_mode, exp_short, exp_long, exp_pressed);
        end
      end
    end
  endtask

  initial begin
    db    = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_short_wrap();
    test_long();
    test_threshold();
    test_reset_mid();
    test_narrow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
